// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a serial shift register.
// One word per valid/ready handshake, one bit per clock, gap-free back-to-back.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fire;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                         : {1'b0, shreg[WIDTH-1:1]};

  assign last     = (state == SHIFT) && (cnt == LAST);
  assign in_ready = !rst && ((state == IDLE) || last);
  assign fire     = in_valid && in_ready;

  // out mirrors the emitting end of shreg, but is its own flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (fire) begin
      state     <= SHIFT;
      shreg     <= in_data;
      cnt       <= '0;
      out       <= head(in_data);
      out_valid <= 1'b1;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            shreg <= nxt;
            cnt   <= cnt + 1'b1;
            out   <= head(nxt);
          end
        end
        default: begin
          state     <= IDLE;
          out       <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: 4-bit MSB-first and 8-bit LSB-first instances
// checked against a bit-queue model of the serial stream.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready, a_out, a_ov, a_busy;
  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_out, b_ov, b_busy;
  logic [3:0] sr;

  int errors = 0;
  int checks = 0;

  logic qa[$];
  logic qb[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .out(a_out), .out_valid(a_ov), .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .out(b_out), .out_valid(b_ov), .busy(b_busy)
  );

  // downstream 4-bit shift register fed by the serial output
  always @(posedge clk) sr <= {sr[2:0], a_out};

  function automatic logic rdy_a();
    return !rst && (qa.size() <= 1);
  endfunction

  function automatic logic rdy_b();
    return !rst && (qb.size() <= 1);
  endfunction

  function automatic logic [2:0] exp_a();
    if (qa.size() == 0) return 3'b000;
    return {qa[0], 2'b11};
  endfunction

  function automatic logic [2:0] exp_b();
    if (qb.size() == 0) return 3'b000;
    return {qb[0], 2'b11};
  endfunction

  // one clock: advance the model with the inputs present before the edge
  task automatic tick();
    logic fa, fb, r;
    fa = a_valid && rdy_a();
    fb = b_valid && rdy_b();
    r  = rst;
    @(posedge clk);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (fa) begin
        qa.delete();
        for (int i = 3; i >= 0; i--) qa.push_back(a_data[i]);
      end else if (qa.size() > 0) begin
        void'(qa.pop_front());
      end
      if (fb) begin
        qb.delete();
        for (int i = 0; i < 8; i++) qb.push_back(b_data[i]);
      end else if (qb.size() > 0) begin
        void'(qb.pop_front());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b1;
    a_data = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (a_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready got=%b exp=0", a_ready);
      end
      tick();
    end
    checks++;
    if ({a_out, a_ov, a_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=000", {a_out, a_ov, a_busy});
    end
    checks++;
    if ({b_out, b_ov, b_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outs_b got=%b exp=000", {b_out, b_ov, b_busy});
    end
    rst = 1'b0;
    a_valid = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=1", a_ready);
    end
  endtask

  task automatic test_single();
    a_data = 4'b1011;
    a_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (a_ready !== rdy_a()) begin
        errors++;
        $display("FAIL single_ready c=%0d got=%b exp=%b", c, a_ready, rdy_a());
      end
      tick();
      a_valid = 1'b0;
      checks++;
      if ({a_out, a_ov, a_busy} !== exp_a()) begin
        errors++;
        $display("FAIL single_outs c=%0d got=%b exp=%b", c,
                 {a_out, a_ov, a_busy}, exp_a());
      end
      if (c == 4) begin
        checks++;
        if (sr !== 4'b1011) begin
          errors++;
          $display("FAIL single_chain got=%b exp=1011", sr);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [2];
    int         w;
    words[0] = 4'b1100;
    words[1] = 4'b0101;
    w = 0;
    a_valid = 1'b1;
    a_data = words[0];
    for (int c = 0; c < 11; c++) begin
      #1;
      checks++;
      if (a_ready !== rdy_a()) begin
        errors++;
        $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, a_ready, rdy_a());
      end
      if (rdy_a() && a_valid) w++;
      tick();
      if (w >= 2) a_valid = 1'b0;
      else a_data = words[w];
      checks++;
      if ({a_out, a_ov, a_busy} !== exp_a()) begin
        errors++;
        $display("FAIL b2b_outs c=%0d got=%b exp=%b", c,
                 {a_out, a_ov, a_busy}, exp_a());
      end
    end
  endtask

  task automatic test_busy_stall();
    a_data = 4'b1001;
    a_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      checks++;
      if (a_ready !== rdy_a()) begin
        errors++;
        $display("FAIL stall_ready c=%0d got=%b exp=%b", c, a_ready, rdy_a());
      end
      tick();
      a_data = 4'($urandom);
      a_valid = (c < 7);
      checks++;
      if ({a_out, a_ov, a_busy} !== exp_a()) begin
        errors++;
        $display("FAIL stall_outs c=%0d got=%b exp=%b", c,
                 {a_out, a_ov, a_busy}, exp_a());
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic test_lsb_wide();
    b_data = 8'h01;
    b_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (b_ready !== rdy_b()) begin
        errors++;
        $display("FAIL lsb_ready c=%0d got=%b exp=%b", c, b_ready, rdy_b());
      end
      tick();
      b_valid = 1'b0;
      checks++;
      if ({b_out, b_ov, b_busy} !== exp_b()) begin
        errors++;
        $display("FAIL lsb_outs c=%0d got=%b exp=%b", c,
                 {b_out, b_ov, b_busy}, exp_b());
      end
    end
  endtask

  task automatic test_reset_mid();
    a_data = 4'b1111;
    a_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rst = (c == 2);
      #1;
      checks++;
      if (a_ready !== rdy_a()) begin
        errors++;
        $display("FAIL midrst_ready c=%0d got=%b exp=%b", c, a_ready, rdy_a());
      end
      tick();
      a_valid = 1'b0;
      checks++;
      if ({a_out, a_ov, a_busy} !== exp_a()) begin
        errors++;
        $display("FAIL midrst_outs c=%0d got=%b exp=%b", c,
                 {a_out, a_ov, a_busy}, exp_a());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_valid = ($urandom_range(3) != 0);
      a_data = 4'($urandom);
      b_valid = ($urandom_range(3) != 0);
      b_data = 8'($urandom);
      rst = ($urandom_range(99) == 0);
      #1;
      checks++;
      if ({a_ready, b_ready} !== {rdy_a(), rdy_b()}) begin
        errors++;
        $display("FAIL rand_ready c=%0d got=%b exp=%b", c,
                 {a_ready, b_ready}, {rdy_a(), rdy_b()});
      end
      tick();
      checks++;
      if ({a_out, a_ov, a_busy, b_out, b_ov, b_busy} !== {exp_a(), exp_b()}) begin
        errors++;
        $display("FAIL rand_outs c=%0d got=%b exp=%b", c,
                 {a_out, a_ov, a_busy, b_out, b_ov, b_busy}, {exp_a(), exp_b()});
      end
    end
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_stall();
    test_lsb_wide();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
